// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcode constants, instruction width and the fetch queue entry.
package mips32_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] OPC_ADD   = 6'b000000;
  localparam logic [5:0] OPC_SUB   = 6'b000001;
  localparam logic [5:0] OPC_AND   = 6'b000010;
  localparam logic [5:0] OPC_OR    = 6'b000011;
  localparam logic [5:0] OPC_SLT   = 6'b000100;
  localparam logic [5:0] OPC_MUL   = 6'b000101;
  localparam logic [5:0] OPC_LW    = 6'b001000;
  localparam logic [5:0] OPC_SW    = 6'b001001;
  localparam logic [5:0] OPC_ADDI  = 6'b001010;
  localparam logic [5:0] OPC_SUBI  = 6'b001011;
  localparam logic [5:0] OPC_SLTI  = 6'b001100;
  localparam logic [5:0] OPC_BNEQZ = 6'b001101;
  localparam logic [5:0] OPC_BEQZ  = 6'b001110;
  localparam logic [5:0] OPC_HLT   = 6'b111111;

  typedef struct packed {
    logic [INSTR_W-1:0] ir;
    logic [31:0]        npc;
  } fetch_entry_t;

endpackage

// File: rtl/mips32_fetch_fifo.sv
// Synchronous FIFO of fetch entries with first-word fall-through head and single-cycle flush.
module mips32_fetch_fifo
  import mips32_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t       mem_q [DEPTH];
  logic [PW-1:0]      wr_q;
  logic [PW-1:0]      rd_q;
  logic [CW-1:0]      cnt_q;

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 IF stage: credit-limited imem reads, in-order return queue, redirect flush/squash.
// Optional MIPS32_FETCH_HLT_STOP_EN: stop issuing after an HLT word is enqueued.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk1,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [AW-1:0]      imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_ir,
  output logic [31:0]        if_npc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] discard_q;
  logic          stopped_q;

  logic [CW-1:0] count;
  logic          empty;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          req_fire;
  logic          rsp_acc;
  logic          push;
  logic          pop;
  logic          hlt_hit;
  logic [CW:0]   credit;

  // Queued entries plus outstanding reads may never exceed DEPTH, so push never overflows.
  assign credit         = {1'b0, count} + {1'b0, inflight_q};
  assign imem_req_valid = !halt_i && !stopped_q && !redirect_valid && (credit < DEPTH_C);
  assign imem_req_addr  = pc_q[AW-1:0];
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_acc   = imem_rsp_valid && (inflight_q != '0);
  assign push      = rsp_acc && (discard_q == '0) && !redirect_valid;
  assign push_data = '{ir: imem_rsp_data, npc: rsp_pc_q + 32'd1};

  assign if_valid = !empty && !redirect_valid;
  assign pop      = if_valid && if_ready;
  assign if_ir    = head.ir;
  assign if_npc   = head.npc;

`ifdef MIPS32_FETCH_HLT_STOP_EN
  assign hlt_hit = push && (imem_rsp_data[31:26] == OPC_HLT);
`else
  assign hlt_hit = 1'b0;
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      stopped_q  <= 1'b0;
    end else if (redirect_valid) begin
      // Every read still outstanding after this edge predates the redirect and must be dropped.
      pc_q       <= redirect_pc;
      rsp_pc_q   <= redirect_pc;
      inflight_q <= inflight_q - CW'(rsp_acc);
      discard_q  <= inflight_q - CW'(rsp_acc);
      stopped_q  <= 1'b0;
    end else begin
      if (req_fire) begin
        pc_q <= pc_q + 32'd1;
      end
      if (rsp_acc && (discard_q == '0)) begin
        rsp_pc_q <= rsp_pc_q + 32'd1;
      end
      if (rsp_acc && (discard_q != '0)) begin
        discard_q <= discard_q - CW'(1);
      end
      inflight_q <= inflight_q + CW'(req_fire) - CW'(rsp_acc);
      if (hlt_hit) begin
        stopped_q <= 1'b1;
      end
    end
  end

  mips32_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Scoreboard bench for mips32_fetch_queue with an in-order variable-latency imem model.
module tb_mips32_fetch_queue;
  import mips32_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b1;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          if_valid;
  logic          if_ready = 1'b1;
  logic [31:0]   if_ir;
  logic [31:0]   if_npc;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          halt_i = 1'b1;

  always #5 clk1 = ~clk1;

  mips32_fetch_queue #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .RESET_PC (32'h0)
  ) dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_ir          (if_ir),
    .if_npc         (if_npc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_i         (halt_i)
  );

  typedef struct {
    int addr;
    int due;
  } rd_t;

  logic [31:0]  mem [1024];
  rd_t          rd_q [$];
  fetch_entry_t exp_q [$];
  int           pop_log [$];
  int           lat = 1;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_pass = 0;

  always @(posedge clk1) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(int a);
    return {8'hA5, 8'(a * 3 + 1), 16'(a)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic exp_push(int a);
    exp_q.push_back('{ir: mem[a], npc: 32'(a + 1)});
  endtask

  // imem model: a fire at edge N returns its word so the DUT samples it at edge N+lat.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk1);
      if (!rst_n) begin
        rd_q.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (rd_q.size() > 0 && rd_q[0].due == cyc + 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem[rd_q[0].addr];
          void'(rd_q.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
        end
        if (imem_req_valid && imem_req_ready)
          rd_q.push_back('{addr: int'(imem_req_addr), due: cyc + 1 + lat});
      end
    end
  end

  // Monitor: every accepted output must match the oldest expected entry.
  initial begin : monitor
    fetch_entry_t e;
    forever begin
      @(negedge clk1);
      if (rst_n && if_valid && if_ready) begin
        pop_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: got ir=%h npc=%h required no output", if_ir, if_npc);
        end else begin
          e = exp_q.pop_front();
          check("if_ir", if_ir, e.ir);
          check("if_npc", if_npc, e.npc);
        end
      end
    end
  end

  // Lets exactly n requests fire, then raises halt_i; returns at posedge+1.
  task automatic issue_n(int n);
    int fired;
    int waited;
    fired  = 0;
    waited = 0;
    @(posedge clk1);
    #1 halt_i = 1'b0;
    while (fired < n && waited < 200) begin
      @(negedge clk1);
      waited++;
      if (imem_req_valid && imem_req_ready) fired++;
    end
    @(posedge clk1);
    #1 halt_i = 1'b1;
    check("issue_count", 32'(fired), 32'(n));
  endtask

  task automatic count_fires(int ncyc, output int fired);
    fired = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk1);
      if (imem_req_valid && imem_req_ready) fired++;
    end
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk1);
      waited++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (8) @(posedge clk1);
    #1;
  endtask

  // Caller must be at posedge+1.
  task automatic pulse_redirect(logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk1);
    #1 redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fired;
    for (int i = 0; i < 1024; i++) mem[i] = word_at(i);

    // Reset state
    repeat (2) @(negedge clk1);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_ir", if_ir, 32'h0);
    check("rst_if_npc", if_npc, 32'h0);
    @(posedge clk1);
    #1 rst_n = 1'b1;
    @(negedge clk1);
    check("rst_addr", 32'(imem_req_addr), 32'h0);

    // Streaming, latency 1: one instruction per cycle after fill
    lat = 1;
    pop_log.delete();
    for (int a = 0; a < 4; a++) exp_push(a);
    issue_n(4);
    wait_drain();
    check("stream_pops", 32'(pop_log.size()), 32'd4);
    if (pop_log.size() == 4) check("stream_span", 32'(pop_log[3] - pop_log[0]), 32'd3);

    // Backpressure: credit caps requests at DEPTH
    if_ready = 1'b0;
    for (int a = 4; a < 8; a++) exp_push(a);
    halt_i = 1'b0;
    count_fires(12, fired);
    check("bp_fires", 32'(fired), 32'd4);
    @(negedge clk1);
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check("bp_if_valid", 32'(if_valid), 32'd1);
    @(posedge clk1);
    #1 halt_i = 1'b1;
    if_ready = 1'b1;
    wait_drain();

    // Redirect with two reads in flight at latency 3
    lat = 3;
    issue_n(2);
    pulse_redirect(32'd120);
    exp_push(120);
    issue_n(1);
    wait_drain();

    // halt_i for 5 cycles mid-stream, latency 2
    lat = 2;
    for (int a = 121; a < 126; a++) exp_push(a);
    issue_n(3);
    count_fires(5, fired);
    check("halt_fires", 32'(fired), 32'd0);
    issue_n(2);
    wait_drain();

`ifdef MIPS32_FETCH_HLT_STOP_EN
    // HLT word stops fetch; redirect restarts it
    lat = 1;
    mem[7] = 32'hfc000000;
    for (int a = 5; a < 9; a++) exp_push(a);
    @(posedge clk1);
    #1 pulse_redirect(32'd5);
    halt_i = 1'b0;
    count_fires(15, fired);
    check("hlt_fires", 32'(fired), 32'd4);
    @(negedge clk1);
    check("hlt_req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk1);
    #1 halt_i = 1'b1;
    wait_drain();
    pulse_redirect(32'd0);
    exp_push(0);
    issue_n(1);
    wait_drain();
    mem[7] = word_at(7);
`endif

    // Reset with the queue full
    lat = 1;
    if_ready = 1'b0;
    halt_i = 1'b0;
    count_fires(10, fired);
    check("full_fires", 32'(fired), 32'd4);
    @(negedge clk1);
    check("full_if_valid", 32'(if_valid), 32'd1);
    @(posedge clk1);
    #1 rst_n = 1'b0;
    halt_i = 1'b1;
    exp_q.delete();
    @(negedge clk1);
    check("mid_rst_if_valid", 32'(if_valid), 32'd0);
    check("mid_rst_if_ir", if_ir, 32'h0);
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk1);
    #1 rst_n = 1'b1;
    @(negedge clk1);
    check("post_rst_addr", 32'(imem_req_addr), 32'h0);
    check("post_rst_if_valid", 32'(if_valid), 32'd0);
    if_ready = 1'b1;
    exp_push(0);
    issue_n(1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
